uart_receiver: RTL and testbench



---
 rtl/uart_receiver.sv | 159 +++++++++++++++
 tb/tb_uart_receiver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: serial-to-parallel UART receiver. Frame is start(0),
// WIDTH data bits LSB first, even parity, stop(1).
// Ports:
//   clk        - system clock, all logic on posedge
//   rstn       - asynchronous active-low reset
//   en         - receiver enable; low blocks start detection / aborts frame
//   rx_data    - serial line, idles high
//   d_out      - last received data word
//   d_valid    - one-cycle strobe when d_out and error flags update
//   parity_err - parity mismatch on last frame
//   frame_err  - stop bit sampled low on last frame
//   busy       - high while a frame is in progress
module uart_receiver #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             rx_data,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(WIDTH + 3);
    localparam int H  = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    // START waits H cycles past detection; unused when H==0
    localparam logic [CW-1:0] CNT_HALF = CW'((H > 0) ? H - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             rx_s;
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] shift_q;
    logic             perr_q;
    logic             brk_q;
    logic [WIDTH-1:0] d_out_q;
    logic             d_valid_q;
    logic             parity_err_q;
    logic             frame_err_q;

    assign rx_s = sync2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_data;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            brk_q        <= 1'b0;
            d_out_q      <= '0;
            d_valid_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            d_valid_q <= 1'b0;
            if (state_q != IDLE && !en) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                idx_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        // a break holds off detection until the line rises
                        if (rx_s) begin
                            brk_q <= 1'b0;
                        end
                        if (en && !rx_s && !brk_q) begin
                            cnt_q <= '0;
                            idx_q <= '0;
                            // with H==0 this edge is the start sample
                            state_q <= (H == 0) ? DATA : START;
                        end
                    end
                    START: begin
                        if (cnt_q == CNT_HALF) begin
                            cnt_q   <= '0;
                            state_q <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            shift_q <= {rx_s, shift_q[WIDTH-1:1]};
                            idx_q   <= idx_q + 1'b1;
                            if (idx_q == IDX_LAST) begin
                                state_q <= PARITY;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            perr_q  <= (^shift_q) != rx_s;
                            state_q <= STOP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q        <= '0;
                            d_out_q      <= shift_q;
                            parity_err_q <= perr_q;
                            frame_err_q  <= ~rx_s;
                            d_valid_q    <= 1'b1;
                            brk_q        <= ~rx_s;
                            state_q      <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign d_out      = d_out_q;
    assign d_valid    = d_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed bench for uart_receiver at
// CLKS_PER_BIT=1 (u1) and CLKS_PER_BIT=4 (u4).
module tb_uart_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       en1, en4;
    logic       rx1, rx4;
    logic [7:0] d1, d4;
    logic       dv1, dv4, pe1, pe4, fe1, fe4, b1, b4;

    uart_receiver #(.WIDTH(8), .CLKS_PER_BIT(1)) u1 (
        .clk(clk), .rstn(rstn), .en(en1), .rx_data(rx1),
        .d_out(d1), .d_valid(dv1), .parity_err(pe1),
        .frame_err(fe1), .busy(b1)
    );

    uart_receiver #(.WIDTH(8), .CLKS_PER_BIT(4)) u4 (
        .clk(clk), .rstn(rstn), .en(en4), .rx_data(rx4),
        .d_out(d4), .d_valid(dv4), .parity_err(pe4),
        .frame_err(fe4), .busy(b4)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n1 = 0, tl1 = 0, tp1 = 0, bc1 = 0;
    int n4 = 0, tl4 = 0, bc4 = 0;
    logic [7:0] dl1 = '0, dp1 = '0;

    always @(negedge clk) begin
        if (dv1) begin
            n1  <= n1 + 1;
            tp1 <= tl1;
            tl1 <= cyc;
            dp1 <= dl1;
            dl1 <= d1;
        end
        if (b1) bc1 <= bc1 + 1;
        if (dv4) begin
            n4  <= n4 + 1;
            tl4 <= cyc;
        end
        if (b4) bc4 <= bc4 + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d,
                                       input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // entered on a negedge; each bit is held c cycles
    task automatic send(input int c, input logic [10:0] f);
        for (int i = 0; i < 11; i++) begin
            if (c == 1) rx1 = f[i];
            else        rx4 = f[i];
            repeat (c) @(negedge clk);
        end
    endtask

    int c0;
    int bs;

    initial begin
        rstn = 1'b0;
        en1  = 1'b1;
        en4  = 1'b1;
        rx1  = 1'b1;
        rx4  = 1'b1;
        idle(3);
        check("rst_dout", d1, 0);
        check("rst_flags", {dv1, pe1, fe1, b1}, 0);
        check("rst_u4", {d4, dv4, pe4, fe4, b4}, 0);
        rstn = 1'b1;
        idle(3);

        rx1 = 1'b0;
        idle(5);
        check("busy_mid", b1, 1);
        rstn = 1'b0;
        #1;
        check("rst_mid_busy", b1, 0);
        check("rst_mid_out", {d1, dv1, pe1, fe1}, 0);
        rx1 = 1'b1;
        idle(2);
        rstn = 1'b1;
        idle(3);

        c0 = cyc;
        send(1, mk(8'hA5, 1'b0, 1'b1));
        idle(4);
        check("a5_count", n1, 1);
        check("a5_lat", tl1 - c0, 13);
        check("a5_data", d1, 8'hA5);
        check("a5_perr", pe1, 0);
        check("a5_ferr", fe1, 0);

        c0 = cyc;
        send(1, mk(8'h3C, 1'b0, 1'b1));
        send(1, mk(8'h3D, 1'b1, 1'b1));
        idle(4);
        check("b2b_count", n1, 3);
        check("b2b_lat", tp1 - c0, 13);
        check("b2b_gap", tl1 - tp1, 11);
        check("b2b_d0", dp1, 8'h3C);
        check("b2b_d1", dl1, 8'h3D);
        check("b2b_err", {pe1, fe1}, 0);

        send(1, mk(8'h01, 1'b0, 1'b1));
        idle(4);
        check("perr_count", n1, 4);
        check("perr_data", d1, 8'h01);
        check("perr_flag", pe1, 1);
        check("perr_ferr", fe1, 0);

        send(1, mk(8'h55, 1'b0, 1'b0));
        idle(4);
        bs = bc1;
        idle(20);
        check("ferr_count", n1, 5);
        check("ferr_data", d1, 8'h55);
        check("ferr_flag", fe1, 1);
        check("ferr_perr", pe1, 0);
        check("brk_nobusy", bc1 - bs, 0);
        rx1 = 1'b1;
        idle(3);
        send(1, mk(8'h81, 1'b0, 1'b1));
        idle(4);
        check("brk_rec_count", n1, 6);
        check("brk_rec_data", d1, 8'h81);
        check("brk_rec_err", {pe1, fe1}, 0);

        begin
            logic [10:0] f;
            f = mk(8'hC3, 1'b0, 1'b1);
            for (int i = 0; i < 11; i++) begin
                if (i == 4) en1 = 1'b0;
                rx1 = f[i];
                @(negedge clk);
            end
        end
        idle(4);
        en1 = 1'b1;
        idle(2);
        check("en_count", n1, 6);
        check("en_data", d1, 8'h81);
        check("en_busy", b1, 0);

        bs = bc4;
        rx4 = 1'b0;
        idle(1);
        rx4 = 1'b1;
        idle(10);
        check("glitch_count", n4, 0);
        check("glitch_busy", b4, 0);
        check("glitch_start", bc4 - bs, 1);

        c0 = cyc;
        send(4, mk(8'hFF, 1'b0, 1'b1));
        idle(6);
        check("os_count", n4, 1);
        check("os_lat", tl4 - c0, 44);
        check("os_data", d4, 8'hFF);
        check("os_err", {pe4, fe4}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
